position_sequencer: RTL and testbench
=====================================

Name: position_sequencer

Overview:
- Controller for the 4-bit button-driven position counter used in the lab boards.
- Manual mode: the operator sets a start position with debounced step presses.
- Run mode: a go press steps the position automatically at a prescaled rate until it equals a target value, then reports done.
- Runs on the board clock with a clock-enable prescaler (no derived clocks). Sits between the debouncers and the seven-segment/LED display logic.

Parameters:
- WIDTH, 4, width of position and target.
- TICK_CYCLES, 25000000, clk_in cycles per automatic step in RUN (>=2; benches use 4).
- PRE_W, 25, prescaler counter width; must hold TICK_CYCLES-1.

Ports:
- clk_in  input  1  board clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- step_in  input  1  debounced step button level, synchronous to clk_in.
- go_in  input  1  debounced go button level, synchronous to clk_in.
- abort_in  input  1  debounced abort button level, synchronous to clk_in.
- target  input  WIDTH  stop position; sampled every cycle.
- pos  output  WIDTH  current position, registered.
- state  output  2  00 IDLE, 01 RUN, 10 DONE; 11 unused.
- busy  output  1  registered, high in RUN only.
- done  output  1  registered, high in DONE only.

Behaviour:
- Reset (rst high at a clk_in edge):
  - pos=0, state=IDLE, busy=0, done=0, prescaler=0.
  - Edge-detect history registers set to 1, so a button held through reset produces no press.
  - Reset overrides all other activity, including mid-RUN.
- Press detection:
  - press_x = x_in & ~x_prev, where x_prev is x_in registered each cycle.
  - A press acts on the same edge at which the high level is first sampled. State and pos change one clock after the input rises.
  - One press per rising level; holding a button does not repeat.
- Priority when presses coincide: abort > go > step. Lower-priority presses in the same cycle are discarded, not queued.
- IDLE:
  - step press: pos <= pos+1, modulo 2^WIDTH (15 -> 0).
  - go press with pos==target: DONE directly, no step taken.
  - go press with pos!=target: RUN, prescaler <= 0.
  - abort press: no effect.
- RUN:
  - Prescaler counts 0..TICK_CYCLES-1 and wraps.
  - On the cycle prescaler==TICK_CYCLES-1: pos <= pos+1 (wrapping). If pos+1==target, state <= DONE on that same edge.
  - First step occurs exactly TICK_CYCLES clocks after entering RUN.
  - step and go presses are ignored.
  - abort press: IDLE, pos held, prescaler <= 0. Abort wins over a coincident terminal-count step: pos is not incremented.
  - A target change during RUN takes effect at the next step comparison. The run continues through wrap-around until pos+1 equals target.
- DONE:
  - pos held.
  - go, step or abort press: IDLE. A step press here does not increment pos.
- busy and done are decoded from the next-state value and registered, so they change on the same edge as state.
- Encoding 11 is unreachable; if entered, go to IDLE on the next edge.

Test Plan:
- Reset then 3 step presses (level high 2 cycles, low 2 cycles each) -> pos=3, state=00, busy=0, done=0; step held high 20 cycles -> pos increments once only.
- pos=3, target=6, TICK_CYCLES=4, go press at edge k -> state=01 after k; pos=4,5,6 after edges k+4, k+8, k+12; state=10, done=1, busy=0 after k+12; pos stays 6.
- pos=14, target=1, go -> pos 15, 0, 1 at 4-cycle spacing, then DONE (wrap-around case).
- pos=5, target=5, go press -> state=10 after one edge, pos=5 unchanged, no RUN cycles.
- RUN with pos=2, target=9, abort press on the prescaler terminal-count cycle -> state=00, pos=2. Go and step pressed in the same cycle in IDLE -> RUN entered, pos unchanged.
- Mid-RUN (pos=7), rst high for 1 cycle -> pos=0, state=00. go_in held high through reset and after -> stays IDLE, no spurious press.

Source files
------------

// File: rtl/position_sequencer.sv
// position_sequencer
// Controller for the 4-bit button-driven position counter on the lab boards.
// In IDLE the operator sets a start position with step presses. A go press
// starts automatic stepping at a prescaled rate until the position reaches
// the target, then the block parks in DONE. The block uses a clock-enable
// prescaler on clk_in and has no derived clocks.

module position_sequencer #(
  parameter int WIDTH       = 4,
  parameter int TICK_CYCLES = 25000000,
  parameter int PRE_W       = 25
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             step_in,
  input  logic             go_in,
  input  logic             abort_in,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pos,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Last prescaler count of an automatic step period.
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] POS_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] POS_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Position increment with natural modulo-2^WIDTH wrap.
  function automatic logic [WIDTH-1:0] pos_inc(input logic [WIDTH-1:0] p);
    return p + POS_ONE;
  endfunction

  // Registered state
  logic [1:0]       state_r;
  logic [WIDTH-1:0] pos_r;
  logic [PRE_W-1:0] pre_r;
  logic             busy_r;
  logic             done_r;
  logic             step_prev_r;
  logic             go_prev_r;
  logic             abort_prev_r;

  // Combinational next values
  logic [1:0]       state_nx_s;
  logic [WIDTH-1:0] pos_nx_s;
  logic [PRE_W-1:0] pre_nx_s;
  logic             busy_nx_s;
  logic             done_nx_s;
  logic             step_press_s;
  logic             go_press_s;
  logic             abort_press_s;
  logic [WIDTH-1:0] pos_plus_s;
  logic             pre_tc_s;

  // A press is the first sampled high level; history is forced high in
  // reset so a button held through reset never registers as a press.
  assign step_press_s  = step_in  & ~step_prev_r;
  assign go_press_s    = go_in    & ~go_prev_r;
  assign abort_press_s = abort_in & ~abort_prev_r;

  assign pos_plus_s = pos_inc(pos_r);
  assign pre_tc_s   = (pre_r == PRE_LAST);

  // Button history registers used for rising-level press detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      step_prev_r  <= 1'b1;
      go_prev_r    <= 1'b1;
      abort_prev_r <= 1'b1;
    end else begin
      step_prev_r  <= step_in;
      go_prev_r    <= go_in;
      abort_prev_r <= abort_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, position and prescaler decode; abort beats go beats step.
  always_comb begin
    state_nx_s = state_r;
    pos_nx_s   = pos_r;
    pre_nx_s   = pre_r;
    case (state_r)
      ST_IDLE: begin
        pre_nx_s = PRE_ZERO;
        if (abort_press_s) begin
          state_nx_s = ST_IDLE;
        end else if (go_press_s) begin
          if (pos_r == target) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else if (step_press_s) begin
          pos_nx_s = pos_plus_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_press_s) begin
          // Abort wins over a coincident terminal-count step.
          state_nx_s = ST_IDLE;
          pre_nx_s   = PRE_ZERO;
        end else if (pre_tc_s) begin
          pre_nx_s = PRE_ZERO;
          pos_nx_s = pos_plus_s;
          if (pos_plus_s == target) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          pre_nx_s = pre_r + PRE_ONE;
        end
      end
      ST_DONE: begin
        pre_nx_s = PRE_ZERO;
        if (abort_press_s || go_press_s || step_press_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        // Unused encoding: recover to IDLE on the next edge.
        state_nx_s = ST_IDLE;
        pre_nx_s   = PRE_ZERO;
      end
    endcase
  end

  // Output decode from the next state so flags move with state.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      ST_IDLE: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
      ST_RUN: begin
        busy_nx_s = 1'b1;
        done_nx_s = 1'b0;
      end
      ST_DONE: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Position and prescaler registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pos_r <= POS_ZERO;
      pre_r <= PRE_ZERO;
    end else begin
      pos_r <= pos_nx_s;
      pre_r <= pre_nx_s;
    end
  end

  // Registered status flags.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  assign pos   = pos_r;
  assign state = state_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_position_sequencer.sv
// Directed bench for position_sequencer with TICK_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_position_sequencer;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       step_in = 1'b0;
  logic       go_in = 1'b0;
  logic       abort_in = 1'b0;
  logic [3:0] target = 4'd0;
  logic [3:0] pos;
  logic [1:0] state;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  position_sequencer #(
    .WIDTH(4),
    .TICK_CYCLES(4),
    .PRE_W(25)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .step_in(step_in),
    .go_in(go_in),
    .abort_in(abort_in),
    .target(target),
    .pos(pos),
    .state(state),
    .busy(busy),
    .done(done)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One step press: high 2 cycles, low 2 cycles.
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      step_in = 1'b1; tick(); tick();
      step_in = 1'b0; tick(); tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    n_cmp++;
    if ({pos, state, busy, done} !== {4'd0, 2'b00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: pos=%0d state=%b busy=%b done=%b expected 0/00/0/0", pos, state, busy, done);
    end
  endtask

  task automatic test_step();
    steps(3);
    n_cmp++;
    if ({pos, state, busy, done} !== {4'd3, 2'b00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL step3: pos=%0d state=%b busy=%b done=%b expected 3/00/0/0", pos, state, busy, done);
    end
    step_in = 1'b1;
    repeat (20) tick();
    step_in = 1'b0; tick();
    n_cmp++;
    if (pos !== 4'd4) begin
      n_err++;
      $display("FAIL step_hold: pos=%0d expected 4", pos);
    end
    // back to 3 via wrap: 15 more presses
    steps(15);
    n_cmp++;
    if (pos !== 4'd3) begin
      n_err++;
      $display("FAIL step_wrap: pos=%0d expected 3", pos);
    end
  endtask

  task automatic test_run();
    target = 4'd6;
    go_in = 1'b1; tick();
    go_in = 1'b0;
    n_cmp++;
    if ({pos, state, busy, done} !== {4'd3, 2'b01, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL run_enter: pos=%0d state=%b busy=%b done=%b expected 3/01/1/0", pos, state, busy, done);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(); tick(); tick();
      n_cmp++;
      if (pos !== 4'(2 + i)) begin
        n_err++;
        $display("FAIL run_early_%0d: pos=%0d expected %0d", i, pos, 2 + i);
      end
      tick();
      n_cmp++;
      if (pos !== 4'(3 + i)) begin
        n_err++;
        $display("FAIL run_step_%0d: pos=%0d expected %0d", i, pos, 3 + i);
      end
    end
    n_cmp++;
    if ({state, busy, done} !== {2'b10, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL run_done: state=%b busy=%b done=%b expected 10/0/1", state, busy, done);
    end
    repeat (5) tick();
    n_cmp++;
    if ({pos, state} !== {4'd6, 2'b10}) begin
      n_err++;
      $display("FAIL done_hold: pos=%0d state=%b expected 6/10", pos, state);
    end
    step_in = 1'b1; tick();
    step_in = 1'b0; tick();
    n_cmp++;
    if ({pos, state, busy, done} !== {4'd6, 2'b00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL done_step_exit: pos=%0d state=%b busy=%b done=%b expected 6/00/0/0", pos, state, busy, done);
    end
  endtask

  task automatic test_wrap();
    steps(8);
    target = 4'd1;
    go_in = 1'b1; tick();
    go_in = 1'b0;
    n_cmp++;
    if ({pos, state} !== {4'd14, 2'b01}) begin
      n_err++;
      $display("FAIL wrap_enter: pos=%0d state=%b expected 14/01", pos, state);
    end
    repeat (4) tick();
    n_cmp++;
    if ({pos, state} !== {4'd15, 2'b01}) begin
      n_err++;
      $display("FAIL wrap_15: pos=%0d state=%b expected 15/01", pos, state);
    end
    repeat (4) tick();
    n_cmp++;
    if ({pos, state} !== {4'd0, 2'b01}) begin
      n_err++;
      $display("FAIL wrap_0: pos=%0d state=%b expected 0/01", pos, state);
    end
    repeat (4) tick();
    n_cmp++;
    if ({pos, state, busy, done} !== {4'd1, 2'b10, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_done: pos=%0d state=%b busy=%b done=%b expected 1/10/0/1", pos, state, busy, done);
    end
    go_in = 1'b1; tick();
    go_in = 1'b0; tick();
    n_cmp++;
    if ({pos, state} !== {4'd1, 2'b00}) begin
      n_err++;
      $display("FAIL done_go_exit: pos=%0d state=%b expected 1/00", pos, state);
    end
  endtask

  task automatic test_go_equal();
    steps(4);
    target = 4'd5;
    go_in = 1'b1; tick();
    go_in = 1'b0;
    n_cmp++;
    if ({pos, state, busy, done} !== {4'd5, 2'b10, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL go_equal: pos=%0d state=%b busy=%b done=%b expected 5/10/0/1", pos, state, busy, done);
    end
    tick();
    abort_in = 1'b1; tick();
    abort_in = 1'b0; tick();
    n_cmp++;
    if ({pos, state} !== {4'd5, 2'b00}) begin
      n_err++;
      $display("FAIL done_abort_exit: pos=%0d state=%b expected 5/00", pos, state);
    end
    abort_in = 1'b1; tick();
    abort_in = 1'b0; tick();
    n_cmp++;
    if ({pos, state} !== {4'd5, 2'b00}) begin
      n_err++;
      $display("FAIL idle_abort: pos=%0d state=%b expected 5/00", pos, state);
    end
  endtask

  task automatic test_abort_tc();
    steps(13);
    target = 4'd9;
    go_in = 1'b1; tick();
    go_in = 1'b0;
    tick(); tick(); tick();
    abort_in = 1'b1; tick();
    abort_in = 1'b0;
    n_cmp++;
    if ({pos, state, busy} !== {4'd2, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL abort_tc: pos=%0d state=%b busy=%b expected 2/00/0", pos, state, busy);
    end
    tick();
    go_in = 1'b1; step_in = 1'b1; tick();
    go_in = 1'b0; step_in = 1'b0;
    n_cmp++;
    if ({pos, state, busy} !== {4'd2, 2'b01, 1'b1}) begin
      n_err++;
      $display("FAIL go_step_same: pos=%0d state=%b busy=%b expected 2/01/1", pos, state, busy);
    end
  endtask

  task automatic test_reset_midrun();
    repeat (20) tick();
    n_cmp++;
    if ({pos, state} !== {4'd7, 2'b01}) begin
      n_err++;
      $display("FAIL midrun_pos: pos=%0d state=%b expected 7/01", pos, state);
    end
    go_in = 1'b1; rst = 1'b1; tick();
    rst = 1'b0;
    n_cmp++;
    if ({pos, state, busy, done} !== {4'd0, 2'b00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrun_reset: pos=%0d state=%b busy=%b done=%b expected 0/00/0/0", pos, state, busy, done);
    end
    repeat (5) tick();
    n_cmp++;
    if ({pos, state, busy} !== {4'd0, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL held_go: pos=%0d state=%b busy=%b expected 0/00/0", pos, state, busy);
    end
    go_in = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_step();
    test_run();
    test_wrap();
    test_go_equal();
    test_abort_tc();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
